// File: rtl/score_keeper_if.sv
// Goal/restart inputs and score/sequencing outputs shared between the ball logic,
// the score keeper and the two score displays.
interface score_keeper_if;
  logic       goal_left;
  logic       goal_right;
  logic       restart;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       freeze;
  logic       serve;
  logic       game_over;
  logic       winner;
  logic       blank_left;
  logic       blank_right;

  modport master (
    output goal_left, goal_right, restart,
    input  score_left, score_right, freeze, serve, game_over, winner,
           blank_left, blank_right
  );

  modport slave (
    input  goal_left, goal_right, restart,
    output score_left, score_right, freeze, serve, game_over, winner,
           blank_left, blank_right
  );
endinterface

// File: rtl/score_keeper.sv
// Match sequencer and per-player goal counters: PLAY -> HOLD -> PLAY ... -> GAME_OVER.
// Optional feature macro: WINNER_BLINK_EN (blinks the winner's score in GAME_OVER).
module score_keeper #(
  parameter int WIN_SCORE    = 5,
  parameter int HOLD_CYCLES  = 25000000
`ifdef WINNER_BLINK_EN
  ,
  parameter int BLINK_CYCLES = 12500000
`endif
) (
  input  logic         clk,
  input  logic         reset_n,
  score_keeper_if.slave sk
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        WIN_VAL   = 4'(WIN_SCORE);

  state_t            state_reg, state_next;
  logic [3:0]        score_left_reg, score_left_next;
  logic [3:0]        score_right_reg, score_right_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              freeze_reg, freeze_next;
  logic              serve_reg, serve_next;
  logic              game_over_reg, game_over_next;
  logic              winner_reg, winner_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= ST_PLAY;
      score_left_reg  <= '0;
      score_right_reg <= '0;
      hold_cnt_reg    <= '0;
      freeze_reg      <= 1'b0;
      serve_reg       <= 1'b0;
      game_over_reg   <= 1'b0;
      winner_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      score_left_reg  <= score_left_next;
      score_right_reg <= score_right_next;
      hold_cnt_reg    <= hold_cnt_next;
      freeze_reg      <= freeze_next;
      serve_reg       <= serve_next;
      game_over_reg   <= game_over_next;
      winner_reg      <= winner_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    score_left_next  = score_left_reg;
    score_right_next = score_right_reg;
    hold_cnt_next    = '0;
    winner_next      = winner_reg;

    unique case (state_reg)
      ST_PLAY: begin
        // Simultaneous goals are treated as a glitch and dropped.
        if (sk.goal_left && !sk.goal_right) begin
          score_left_next = score_left_reg + 4'd1;
          if (score_left_next == WIN_VAL) begin
            state_next  = ST_OVER;
            winner_next = 1'b0;
          end else begin
            state_next = ST_HOLD;
          end
        end else if (sk.goal_right && !sk.goal_left) begin
          score_right_next = score_right_reg + 4'd1;
          if (score_right_next == WIN_VAL) begin
            state_next  = ST_OVER;
            winner_next = 1'b1;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_PLAY;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_OVER: begin
        if (sk.restart) begin
          state_next       = ST_PLAY;
          score_left_next  = '0;
          score_right_next = '0;
        end
      end
      default: state_next = ST_PLAY;
    endcase

    freeze_next    = (state_next != ST_PLAY);
    game_over_next = (state_next == ST_OVER);
    serve_next     = (state_reg == ST_HOLD) && (state_next == ST_PLAY);
  end

`ifdef WINNER_BLINK_EN
  localparam int                BLINK_W    = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic               blank_left_reg, blank_left_next;
  logic               blank_right_reg, blank_right_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_reg   <= '0;
      blank_left_reg  <= 1'b0;
      blank_right_reg <= 1'b0;
    end else begin
      blink_cnt_reg   <= blink_cnt_next;
      blank_left_reg  <= blank_left_next;
      blank_right_reg <= blank_right_next;
    end
  end

  // Counter and blanks only run while staying in GAME_OVER; entry and exit clear them.
  always_comb begin
    blink_cnt_next   = '0;
    blank_left_next  = 1'b0;
    blank_right_next = 1'b0;
    if (state_reg == ST_OVER && state_next == ST_OVER) begin
      blank_left_next  = blank_left_reg;
      blank_right_next = blank_right_reg;
      if (blink_cnt_reg == BLINK_LAST) begin
        if (winner_reg) blank_right_next = ~blank_right_reg;
        else            blank_left_next  = ~blank_left_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 1'b1;
      end
    end
  end

  assign sk.blank_left  = blank_left_reg;
  assign sk.blank_right = blank_right_reg;
`else
  assign sk.blank_left  = 1'b0;
  assign sk.blank_right = 1'b0;
`endif

  assign sk.score_left  = score_left_reg;
  assign sk.score_right = score_right_reg;
  assign sk.freeze      = freeze_reg;
  assign sk.serve       = serve_reg;
  assign sk.game_over   = game_over_reg;
  assign sk.winner      = winner_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Directed match scenarios followed by random goal/restart/reset traffic, all compared
// cycle by cycle against a countdown-based behavioural model of the match rules.
module tb_score_keeper;
  localparam int WIN   = 3;
  localparam int HOLD  = 4;
  localparam int BLINK = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  score_keeper_if sk();

  score_keeper #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLD)
`ifdef WINNER_BLINK_EN
    ,
    .BLINK_CYCLES(BLINK)
`endif
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sk     (sk)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: frozen time is tracked as a remaining-cycles countdown, GAME_OVER as a flag.
  int m_sl = 0, m_sr = 0, m_hold_rem = 0, m_over_cyc = 0;
  bit m_over = 0, m_win = 0, m_serve = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_sl = 0; m_sr = 0; m_hold_rem = 0; m_over_cyc = 0;
      m_over = 0; m_win = 0; m_serve = 0;
    end else begin
      m_serve = 0;
      if (m_over) begin
        if (sk.restart) begin
          m_over = 0; m_sl = 0; m_sr = 0;
        end else begin
          m_over_cyc++;
        end
      end else if (m_hold_rem > 0) begin
        m_hold_rem--;
        if (m_hold_rem == 0) m_serve = 1;
      end else if (sk.goal_left != sk.goal_right) begin
        if (sk.goal_left) m_sl++;
        else              m_sr++;
        if (m_sl == WIN || m_sr == WIN) begin
          m_over = 1; m_win = sk.goal_right; m_over_cyc = 0;
        end else begin
          m_hold_rem = HOLD;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit blink_on;
    blink_on = 0;
`ifdef WINNER_BLINK_EN
    blink_on = m_over && (((m_over_cyc / BLINK) % 2) == 1);
`endif
    check("score_left",  32'(sk.score_left),  32'(m_sl));
    check("score_right", 32'(sk.score_right), 32'(m_sr));
    check("freeze",      32'(sk.freeze),      32'(m_over || m_hold_rem > 0));
    check("serve",       32'(sk.serve),       32'(m_serve));
    check("game_over",   32'(sk.game_over),   32'(m_over));
    if (m_over) check("winner", 32'(sk.winner), 32'(m_win));
    check("blank_left",  32'(sk.blank_left),  32'(blink_on && !m_win));
    check("blank_right", 32'(sk.blank_right), 32'(blink_on && m_win));
  endtask

  task automatic step(input bit gl, input bit gr, input bit rs, input bit rn);
    sk.goal_left  = gl;
    sk.goal_right = gr;
    sk.restart    = rs;
    reset_n       = rn;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    sk.goal_left = 0; sk.goal_right = 0; sk.restart = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("reset_freeze", 32'(sk.freeze), 0);
    idle(2);

    // 1: reset mid-hold with 1/0
    step(1, 0, 0, 1);
    idle(1);
    check("t1_pre_score_l", 32'(sk.score_left), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t1_score_l", 32'(sk.score_left), 0);
    check("t1_freeze", 32'(sk.freeze), 0);
    idle(2);

    // 2: goal_left, four frozen cycles, single serve pulse
    step(1, 0, 0, 1);
    check("t2_score_l", 32'(sk.score_left), 1);
    check("t2_freeze0", 32'(sk.freeze), 1);
    idle(3);
    check("t2_freeze3", 32'(sk.freeze), 1);
    idle(1);
    check("t2_serve", 32'(sk.serve), 1);
    check("t2_unfreeze", 32'(sk.freeze), 0);
    idle(1);
    check("t2_serve_off", 32'(sk.serve), 0);

    // 3: simultaneous goals ignored
    step(1, 1, 0, 1);
    check("t3_freeze", 32'(sk.freeze), 0);
    check("t3_score_r", 32'(sk.score_right), 0);
    idle(1);

    // 4: goals during hold ignored
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    step(0, 1, 1, 1);
    idle(3);
    check("t4_score_r", 32'(sk.score_right), 1);

    // 5: right wins, goals ignored, blink, restart
    step(0, 1, 0, 1);
    idle(5);
    step(0, 1, 0, 1);
    check("t5_game_over", 32'(sk.game_over), 1);
    check("t5_winner", 32'(sk.winner), 1);
    check("t5_serve", 32'(sk.serve), 0);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    idle(8);
    check("t5_score_r", 32'(sk.score_right), 3);
    check("t6_blank_l", 32'(sk.blank_left), 0);
    step(0, 0, 1, 1);
    check("t5_restart_go", 32'(sk.game_over), 0);
    check("t5_restart_fz", 32'(sk.freeze), 0);
    check("t5_restart_sr", 32'(sk.score_right), 0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit gl, gr, rs, rn;
      r  = int'($urandom_range(0, 99));
      gl = (r < 10) || (r == 20);
      gr = (r >= 10 && r < 20) || (r == 20);
      rs = ($urandom_range(0, 29) == 0);
      rn = ($urandom_range(0, 399) != 0);
      step(gl, gr, rs, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
